fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_pkg.sv | 14 +
 rtl/fb_wbuf.sv | 50 +++++
 rtl/fb_arbiter.sv | 152 +++++++++++++++
 tb/tb_fb_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, bus widths and arbiter state encoding.
package fb_pkg;
   localparam int FB_COLS  = 336;
   localparam int FB_ROWS  = 240;
   localparam int FB_WORDS = FB_COLS * FB_ROWS;
   localparam int ADDR_W   = 17;
   localparam int DATA_W   = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      CLEAR = 2'd2
   } fb_state_e;
endpackage

// File: rtl/fb_wbuf.sv
// Posted-write FIFO; the caller never pushes when full or pops when empty.
module fb_wbuf #(
   parameter  int WIDTH = 33,
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count,
   output logic             empty
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] entries_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) entries_q[wr_ptr_q] <= push_data;
   end

   assign head_data = entries_q[rd_ptr_q];
   assign count     = count_q;
   assign empty     = (count_q == '0);
endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: scanout reads, posted writes and a full-screen clear.
//
//   state | meaning
//   IDLE  | normal traffic, host writes accepted into the buffer
//   DRAIN | clear requested, flushing buffered writes first
//   CLEAR | sweeping every word with the latched colour
module fb_arbiter #(
   parameter  int ADDR_W       = fb_pkg::ADDR_W,
   parameter  int DATA_W       = fb_pkg::DATA_W,
   parameter  int WBUF_DEPTH   = 4,
   parameter  int STARVE_LIMIT = 8,
   parameter  int FB_WORDS     = fb_pkg::FB_WORDS,
   localparam int CNT_W        = $clog2(WBUF_DEPTH + 1)
) (
   input  logic              CLOCK_100,
   input  logic              reset,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_gnt,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              clear_start,
   input  logic [DATA_W-1:0] clear_color,
   output logic              clear_busy,
   output logic              clear_done,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  wbuf_count
);
   import fb_pkg::*;

   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   fb_state_e          state_q, state_d;
   logic [STV_W-1:0]   starve_left_q, starve_left_d;
   logic [ADDR_W-1:0]  clear_addr_q, clear_addr_d;
   logic [DATA_W-1:0]  clear_color_q, clear_color_d;
   logic               clear_done_q, clear_done_d;
   logic               rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]  rd_hold_q, rd_hold_d;

   logic                     push, pop, wbuf_empty, src_pend, issue_rd, issue_wr;
   logic [ADDR_W+DATA_W-1:0] head;
   logic [ADDR_W-1:0]        src_addr;
   logic [DATA_W-1:0]        src_data;
   logic [CNT_W-1:0]         wbuf_cnt_nxt;

   fb_wbuf #(.WIDTH(ADDR_W + DATA_W), .DEPTH(WBUF_DEPTH)) u_wbuf (
      .clk       (CLOCK_100),
      .reset     (reset),
      .push      (push),
      .push_data ({wr_addr, wr_data}),
      .pop       (pop),
      .head_data (head),
      .count     (wbuf_count),
      .empty     (wbuf_empty)
   );

   // During a clear the sweep counter stands in for the write buffer.
   assign src_pend = (state_q == CLEAR) ? 1'b1 : !wbuf_empty;
   assign src_addr = (state_q == CLEAR) ? clear_addr_q  : head[ADDR_W+DATA_W-1:DATA_W];
   assign src_data = (state_q == CLEAR) ? clear_color_q : head[DATA_W-1:0];

   assign wr_ready     = (wbuf_count != CNT_W'(WBUF_DEPTH)) && (state_q == IDLE);
   assign push         = wr_valid && wr_ready;
   assign pop          = issue_wr && (state_q != CLEAR);
   assign wbuf_cnt_nxt = wbuf_count + CNT_W'(push) - CNT_W'(pop);

   always_comb begin
      issue_rd = 1'b0;
      issue_wr = 1'b0;
      if (!reset) begin
         if (rd_req && starve_left_q != '0) issue_rd = 1'b1;
         else if (src_pend)                 issue_wr = 1'b1;
         else if (rd_req)                   issue_rd = 1'b1;
      end
   end

   always_comb begin
      state_d       = state_q;
      starve_left_d = starve_left_q;
      clear_addr_d  = clear_addr_q;
      clear_color_d = clear_color_q;
      clear_done_d  = 1'b0;
      rd_valid_d    = issue_rd;
      rd_hold_d     = rd_valid_q ? mem_rdata : rd_hold_q;

      if (issue_wr || !src_pend)     starve_left_d = STV_W'(STARVE_LIMIT);
      else if (starve_left_q != '0)  starve_left_d = starve_left_q - STV_W'(1);

      case (state_q)
         IDLE: begin
            if (clear_start) begin
               clear_color_d = clear_color;
               state_d       = (wbuf_cnt_nxt != '0) ? DRAIN : CLEAR;
            end
         end
         DRAIN: begin
            if (wbuf_cnt_nxt == '0) state_d = CLEAR;
         end
         CLEAR: begin
            if (issue_wr) begin
               if (clear_addr_q == ADDR_W'(FB_WORDS - 1)) begin
                  clear_addr_d = '0;
                  clear_done_d = 1'b1;
                  state_d      = IDLE;
               end else begin
                  clear_addr_d = clear_addr_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_100) begin
      if (reset) begin
         state_q       <= IDLE;
         starve_left_q <= STV_W'(STARVE_LIMIT);
         clear_addr_q  <= '0;
         clear_color_q <= '0;
         clear_done_q  <= 1'b0;
         rd_valid_q    <= 1'b0;
         rd_hold_q     <= '0;
      end else begin
         state_q       <= state_d;
         starve_left_q <= starve_left_d;
         clear_addr_q  <= clear_addr_d;
         clear_color_q <= clear_color_d;
         clear_done_q  <= clear_done_d;
         rd_valid_q    <= rd_valid_d;
         rd_hold_q     <= rd_hold_d;
      end
   end

   assign rd_gnt     = issue_rd;
   assign mem_en     = issue_rd || issue_wr;
   assign mem_we     = issue_wr;
   assign mem_addr   = issue_wr ? src_addr : (issue_rd ? rd_addr : '0);
   assign mem_wdata  = issue_wr ? src_data : '0;
   assign rd_valid   = rd_valid_q;
   assign rd_data    = rd_valid_q ? mem_rdata : rd_hold_q;
   assign clear_busy = (state_q != IDLE);
   assign clear_done = clear_done_q;
endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: vector table plus starvation, full-buffer, clear and reset sequences.
module tb_fb_arbiter;
   logic        CLOCK_100 = 1'b0;
   logic        reset;
   logic        wr_valid, wr_ready;
   logic [16:0] wr_addr;
   logic [15:0] wr_data;
   logic        rd_req, rd_gnt, rd_valid;
   logic [16:0] rd_addr;
   logic [15:0] rd_data;
   logic        clear_start, clear_busy, clear_done;
   logic [15:0] clear_color;
   logic        mem_en, mem_we;
   logic [16:0] mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic [2:0]  wbuf_count;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] ram [0:(1<<17)-1];

   fb_arbiter dut (
      .CLOCK_100(CLOCK_100), .reset(reset),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
      .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy),
      .clear_done(clear_done), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .wbuf_count(wbuf_count)
   );

   always #5 CLOCK_100 = ~CLOCK_100;

   // Memory model: one-cycle read latency, preloaded read targets.
   always @(posedge CLOCK_100) begin
      if (reset) begin
         ram[16] <= 16'h0F0;
         ram[17] <= 16'h1B2;
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   typedef struct {
      logic        rd_req;
      logic [16:0] rd_addr;
      logic        wr_valid;
      logic [16:0] wr_addr;
      logic [15:0] wr_data;
      logic        e_wr_ready, e_rd_gnt, e_mem_en, e_mem_we;
      logic [16:0] e_mem_addr;
      logic [15:0] e_mem_wdata;
      logic [2:0]  e_count;
      logic        e_rd_valid;
      logic [15:0] e_rd_data;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic rq, input logic [16:0] ra, input logic wv, input logic [16:0] wa,
                      input logic [15:0] wd, input logic ery, input logic eg, input logic een,
                      input logic ewe, input logic [16:0] ea, input logic [15:0] ewd,
                      input logic [2:0] ec, input logic erv, input logic [15:0] erd);
      vq.push_back('{rq, ra, wv, wa, wd, ery, eg, een, ewe, ea, ewd, ec, erv, erd});
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK_100);
      #1;
   endtask

   task automatic idle_inputs();
      wr_valid = 0; wr_addr = '0; wr_data = '0;
      rd_req = 0; rd_addr = '0;
      clear_start = 0; clear_color = '0;
   endtask

   initial begin
      int acc, cyc, first_wr, acc5, idx, bad, busy_bad, done_cyc, last_wr, found;
      logic done_busy;

      reset = 1;
      idle_inputs();
      repeat (3) tick();
      reset = 0;
      @(negedge CLOCK_100);
      chk("rst_wbuf_count", wbuf_count, 0);
      chk("rst_rd_valid",   rd_valid, 0);
      chk("rst_rd_data",    rd_data, 0);
      chk("rst_mem_en",     mem_en, 0);
      chk("rst_mem_we",     mem_we, 0);
      chk("rst_mem_addr",   mem_addr, 0);
      chk("rst_mem_wdata",  mem_wdata, 0);
      chk("rst_clear_busy", clear_busy, 0);
      chk("rst_clear_done", clear_done, 0);
      chk("rst_wr_ready",   wr_ready, 1);

      //   rq  ra     wv wa     wd       | rdy gnt en we addr   wdata   cnt rv rdata
      add(0, 0,     1, 0,     16'h0A0,   1,  0,  0, 0, 0,     16'h000, 0, 0, 16'h000);
      add(0, 0,     1, 1,     16'h0A1,   1,  0,  1, 1, 0,     16'h0A0, 1, 0, 16'h000);
      add(0, 0,     1, 2,     16'h0A2,   1,  0,  1, 1, 1,     16'h0A1, 1, 0, 16'h000);
      add(0, 0,     1, 3,     16'h0A3,   1,  0,  1, 1, 2,     16'h0A2, 1, 0, 16'h000);
      add(0, 0,     0, 0,     16'h000,   1,  0,  1, 1, 3,     16'h0A3, 1, 0, 16'h000);
      add(1, 'h10,  0, 0,     16'h000,   1,  1,  1, 0, 'h10,  16'h000, 0, 0, 16'h000);
      add(0, 0,     0, 0,     16'h000,   1,  0,  0, 0, 0,     16'h000, 0, 1, 16'h0F0);
      add(0, 0,     0, 0,     16'h000,   1,  0,  0, 0, 0,     16'h000, 0, 0, 16'h0F0);
      add(1, 3,     0, 0,     16'h000,   1,  1,  1, 0, 3,     16'h000, 0, 0, 16'h0F0);
      add(1, 'h11,  0, 0,     16'h000,   1,  1,  1, 0, 'h11,  16'h000, 0, 1, 16'h0A3);
      add(0, 0,     0, 0,     16'h000,   1,  0,  0, 0, 0,     16'h000, 0, 1, 16'h1B2);
      add(1, 'h10,  1, 'h10,  16'h123,   1,  1,  1, 0, 'h10,  16'h000, 0, 0, 16'h1B2);
      add(1, 'h10,  0, 0,     16'h000,   1,  1,  1, 0, 'h10,  16'h000, 1, 1, 16'h0F0);
      add(0, 0,     0, 0,     16'h000,   1,  0,  1, 1, 'h10,  16'h123, 1, 1, 16'h0F0);
      add(1, 'h10,  0, 0,     16'h000,   1,  1,  1, 0, 'h10,  16'h000, 0, 0, 16'h0F0);
      add(0, 0,     0, 0,     16'h000,   1,  0,  0, 0, 0,     16'h000, 0, 1, 16'h123);

      foreach (vq[i]) begin
         tick();
         rd_req = vq[i].rd_req;     rd_addr = vq[i].rd_addr;
         wr_valid = vq[i].wr_valid; wr_addr = vq[i].wr_addr; wr_data = vq[i].wr_data;
         @(negedge CLOCK_100);
         chk($sformatf("v%0d_wr_ready", i),   wr_ready,   vq[i].e_wr_ready);
         chk($sformatf("v%0d_rd_gnt", i),     rd_gnt,     vq[i].e_rd_gnt);
         chk($sformatf("v%0d_mem_en", i),     mem_en,     vq[i].e_mem_en);
         chk($sformatf("v%0d_mem_we", i),     mem_we,     vq[i].e_mem_we);
         chk($sformatf("v%0d_mem_addr", i),   mem_addr,   vq[i].e_mem_addr);
         chk($sformatf("v%0d_mem_wdata", i),  mem_wdata,  vq[i].e_mem_wdata);
         chk($sformatf("v%0d_wbuf_count", i), wbuf_count, vq[i].e_count);
         chk($sformatf("v%0d_rd_valid", i),   rd_valid,   vq[i].e_rd_valid);
         chk($sformatf("v%0d_rd_data", i),    rd_data,    vq[i].e_rd_data);
         chk($sformatf("v%0d_clear_busy", i), clear_busy, 0);
      end

      // Starvation: one write pending under continuous reads.
      tick();
      idle_inputs();
      rd_req = 1; rd_addr = 'h20; wr_valid = 1; wr_addr = 'h40; wr_data = 16'h0C0;
      @(negedge CLOCK_100);
      chk("starve_push_rd_gnt", rd_gnt, 1);
      for (int i = 1; i <= 9; i++) begin
         tick();
         wr_valid = 0;
         @(negedge CLOCK_100);
         if (i <= 8) begin
            chk($sformatf("starve_rd%0d_gnt", i), rd_gnt, 1);
            chk($sformatf("starve_rd%0d_we", i),  mem_we, 0);
         end else begin
            chk("starve_forced_rd_gnt", rd_gnt, 0);
            chk("starve_forced_we",     mem_we, 1);
            chk("starve_forced_addr",   mem_addr, 'h40);
            chk("starve_forced_wdata",  mem_wdata, 16'h0C0);
         end
      end
      tick();
      idle_inputs();
      @(negedge CLOCK_100);
      chk("starve_after_count", wbuf_count, 0);

      // Full buffer: five writes offered with reads always requested.
      acc = 0; cyc = 0; first_wr = -1; acc5 = -1;
      while (acc < 5 && cyc < 40) begin
         tick();
         rd_req = 1; rd_addr = 'h60;
         wr_valid = 1; wr_addr = 17'('h50 + acc); wr_data = 16'(16'h0D0 + acc);
         @(negedge CLOCK_100);
         cyc++;
         if (mem_we && first_wr < 0) first_wr = cyc;
         if (cyc == 5) begin
            chk("full_count", wbuf_count, 4);
            chk("full_wr_ready", wr_ready, 0);
         end
         if (wr_ready) begin
            acc++;
            if (acc == 5) acc5 = cyc;
         end
      end
      chk("full_first_write_cycle", first_wr, 10);
      chk("full_fifth_accept_cycle", acc5, 11);
      tick();
      idle_inputs();
      cyc = 0;
      while (cyc < 10 && (wbuf_count != 0 || mem_en)) begin
         tick();
         cyc++;
      end
      tick();
      for (int i = 0; i < 5; i++)
         chk($sformatf("full_ram%0d", i), ram[17'('h50 + i)], 16'(16'h0D0 + i));

      // Clear with two buffered writes in front of it.
      tick();
      wr_valid = 1; wr_addr = 'h100; wr_data = 16'h111;
      tick();
      wr_addr = 'h101; wr_data = 16'h222; clear_start = 1; clear_color = 16'h00F;
      @(negedge CLOCK_100);
      chk("clr_push2_ready", wr_ready, 1);
      chk("clr_drain1_addr", mem_addr, 'h100);
      chk("clr_drain1_wdata", mem_wdata, 16'h111);
      tick();
      idle_inputs();
      @(negedge CLOCK_100);
      chk("clr_drain_busy", clear_busy, 1);
      chk("clr_drain2_addr", mem_addr, 'h101);
      chk("clr_drain2_wdata", mem_wdata, 16'h222);
      idx = 0; bad = 0; busy_bad = 0; done_cyc = -1; last_wr = -1; done_busy = 1'b1;
      for (int c = 0; c < 81000 && done_cyc < 0; c++) begin
         tick();
         @(negedge CLOCK_100);
         if (clear_done) begin
            done_cyc = c;
            done_busy = clear_busy;
         end else begin
            if (!clear_busy) busy_bad++;
            if (mem_en && mem_we) begin
               if (mem_addr != 17'(idx) || mem_wdata != 16'h00F) bad++;
               idx++;
               last_wr = c;
            end
         end
      end
      chk("clr_bad_writes", bad, 0);
      chk("clr_write_count", idx, 80640);
      chk("clr_busy_drop_early", busy_bad, 0);
      chk("clr_done_timing", done_cyc, last_wr + 1);
      chk("clr_busy_at_done", done_busy, 0);
      tick();
      @(negedge CLOCK_100);
      chk("clr_done_single", clear_done, 0);

      // Reset partway through a clear, with a read issued just before reset.
      tick();
      clear_start = 1; clear_color = 16'h0F0;
      @(negedge CLOCK_100);
      chk("rclr_start_busy", clear_busy, 0);
      tick();
      idle_inputs();
      found = 0;
      for (int c = 0; c < 1100 && found == 0; c++) begin
         @(negedge CLOCK_100);
         if (mem_we && mem_addr == 17'd1000) found = 1;
         else tick();
      end
      chk("rclr_reached_1000", found, 1);
      tick();
      rd_req = 1; rd_addr = 'h11;
      @(negedge CLOCK_100);
      chk("rclr_read_before_reset", rd_gnt, 1);
      tick();
      rd_req = 0; reset = 1;
      tick();
      reset = 0;
      @(negedge CLOCK_100);
      chk("rclr_busy", clear_busy, 0);
      chk("rclr_done", clear_done, 0);
      chk("rclr_count", wbuf_count, 0);
      chk("rclr_rd_valid", rd_valid, 0);
      chk("rclr_rd_data", rd_data, 0);
      chk("rclr_mem_en", mem_en, 0);
      bad = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         @(negedge CLOCK_100);
         if (clear_done || clear_busy || mem_en) bad++;
      end
      chk("rclr_quiet_after", bad, 0);

      // Reset discards buffered writes.
      tick();
      rd_req = 1; rd_addr = 'h10; wr_valid = 1; wr_addr = 'h70; wr_data = 16'h001;
      tick();
      wr_addr = 'h71; wr_data = 16'h002;
      @(negedge CLOCK_100);
      chk("disc_count_before", wbuf_count, 1);
      tick();
      idle_inputs();
      reset = 1;
      tick();
      reset = 0;
      @(negedge CLOCK_100);
      chk("disc_count_after", wbuf_count, 0);
      tick();
      @(negedge CLOCK_100);
      chk("disc_no_write", mem_en, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
